// File: rtl/alu_share_arbiter.sv
// Two-requester front end for one shared combinational 8-bit ALU. Each operation is
// a round-robin handshake, then SETTLE cycles of stable operands, then a one-cycle tagged response.
module alu_share_arbiter #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned SETTLE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_cin,
  input  logic [3:0]       req0_sel,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_cin,
  input  logic [3:0]       req1_sel,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic             alu_cin,
  output logic [3:0]       alu_s,
  input  logic [WIDTH-1:0] alu_d,
  input  logic             alu_cout,
  input  logic             alu_z,
  output logic             rsp_valid,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_d,
  output logic             rsp_cout,
  output logic             rsp_z,
  output logic             busy
);

  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t           state;
  state_t           state_nxt;
  logic             last;
  logic             id_q;
  logic [CNT_W-1:0] cnt;
  logic             grant0;
  logic             grant1;
  logic             accept;
  logic             capture;

  // Round-robin: on contention the requester served most recently loses.
  assign grant0 = req0_valid && (!req1_valid || last);
  assign grant1 = req1_valid && (!req0_valid || !last);

  assign req0_ready = (state == IDLE) && grant0;
  assign req1_ready = (state == IDLE) && grant1;
  assign rsp_valid  = (state == RESP);
  assign busy       = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        if (grant0 || grant1) begin
          accept    = 1'b1;
          state_nxt = EXEC;
        end
      end
      EXEC: begin
        if (cnt == CNT_W'(1)) begin
          capture   = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operand, counter and response registers; ALU inputs only move on accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last     <= 1'b1;
      id_q     <= 1'b0;
      cnt      <= '0;
      alu_a    <= '0;
      alu_b    <= '0;
      alu_cin  <= 1'b0;
      alu_s    <= 4'b0;
      rsp_id   <= 1'b0;
      rsp_d    <= '0;
      rsp_cout <= 1'b0;
      rsp_z    <= 1'b0;
    end else begin
      if (accept) begin
        id_q    <= grant1;
        cnt     <= CNT_W'(SETTLE);
        alu_a   <= grant1 ? req1_a   : req0_a;
        alu_b   <= grant1 ? req1_b   : req0_b;
        alu_cin <= grant1 ? req1_cin : req0_cin;
        alu_s   <= grant1 ? req1_sel : req0_sel;
      end else if (state == EXEC) begin
        cnt <= cnt - CNT_W'(1);
      end
      if (capture) begin
        rsp_id   <= id_q;
        rsp_d    <= alu_d;
        rsp_cout <= alu_cout;
        rsp_z    <= alu_z;
      end
      if (state == RESP) last <= rsp_id;
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench: one SETTLE=1 arbiter driving a modelled ALU, plus a SETTLE=3
// instance whose ALU outputs are scripted cycle by cycle.
module tb_alu_share_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  always #5 clk = ~clk;

  // SETTLE=1 instance
  logic       r0v, r0rdy, r0cin, r1v, r1rdy, r1cin;
  logic [7:0] r0a, r0b, r1a, r1b;
  logic [3:0] r0sel, r1sel;
  logic [7:0] aa, ab, ad, rd;
  logic [3:0] as;
  logic       acin, acout, az, rv, rid, rcout, rz, bsy;

  // SETTLE=3 instance
  logic       q0v, q0rdy, q1rdy;
  logic [7:0] q0a, q0b;
  logic [3:0] q0sel;
  logic [7:0] a3a, a3b, a3d, r3d;
  logic [3:0] a3s;
  logic       a3cin, a3c, a3z, r3v, r3id, r3c, r3z, bsy3;

  int checks = 0;
  int errors = 0;

  alu_share_arbiter #(.WIDTH(8), .SETTLE(1)) u_dut (
    .clk(clk), .rst(rst),
    .req0_valid(r0v), .req0_ready(r0rdy), .req0_a(r0a), .req0_b(r0b),
    .req0_cin(r0cin), .req0_sel(r0sel),
    .req1_valid(r1v), .req1_ready(r1rdy), .req1_a(r1a), .req1_b(r1b),
    .req1_cin(r1cin), .req1_sel(r1sel),
    .alu_a(aa), .alu_b(ab), .alu_cin(acin), .alu_s(as),
    .alu_d(ad), .alu_cout(acout), .alu_z(az),
    .rsp_valid(rv), .rsp_id(rid), .rsp_d(rd), .rsp_cout(rcout), .rsp_z(rz),
    .busy(bsy)
  );

  alu_share_arbiter #(.WIDTH(8), .SETTLE(3)) u_dut3 (
    .clk(clk), .rst(rst),
    .req0_valid(q0v), .req0_ready(q0rdy), .req0_a(q0a), .req0_b(q0b),
    .req0_cin(1'b0), .req0_sel(q0sel),
    .req1_valid(1'b0), .req1_ready(q1rdy), .req1_a(8'h00), .req1_b(8'h00),
    .req1_cin(1'b0), .req1_sel(4'h0),
    .alu_a(a3a), .alu_b(a3b), .alu_cin(a3cin), .alu_s(a3s),
    .alu_d(a3d), .alu_cout(a3c), .alu_z(a3z),
    .rsp_valid(r3v), .rsp_id(r3id), .rsp_d(r3d), .rsp_cout(r3c), .rsp_z(r3z),
    .busy(bsy3)
  );

  // Reference ALU: returns {cout, d}
  function automatic logic [8:0] alu_f(input logic [7:0] a, b, input logic cin,
                                       input logic [3:0] s);
    logic [8:0] r;
    case (s)
      4'b0000: r = {1'b0, a} + {1'b0, b} + 9'(cin);
      4'b0100: r = {1'b0, a} - {1'b0, b};
      4'b1000: r = {1'b0, a & b};
      4'b1100: r = {1'b0, a | b};
      default: r = {1'b0, a ^ b};
    endcase
    return r;
  endfunction

  logic [8:0] alu_r;
  always_comb begin
    alu_r = alu_f(aa, ab, acin, as);
    ad    = alu_r[7:0];
    acout = alu_r[8];
    az    = (alu_r[7:0] == 8'h00);
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
    end
  endtask

  // Runs n operations with the enabled requesters held valid; checks grant order,
  // 3-cycle spacing, operands on the ALU, and every tagged response.
  task automatic run_ops(input int n, input bit en0, input bit en1, input bit first_id);
    int         ngrant = 0;
    int         nrsp = 0;
    int         first_cyc = 0;
    logic       exp_id;
    logic [7:0] exp_a;
    logic       id_q[$];
    logic [7:0] d_q[$];
    logic [3:0] sels[4] = '{4'b0000, 4'b0100, 4'b1000, 4'b1100};
    logic [8:0] r;
    for (int cyc = 0; cyc < 12 * n + 10 && nrsp < n; cyc++) begin
      @(negedge clk);
      r0v   = en0 && (ngrant < n);
      r1v   = en1 && (ngrant < n);
      r0a   = 8'h10 + 8'(ngrant); r0b = 8'h05; r0cin = 1'b0; r0sel = sels[ngrant % 4];
      r1a   = 8'h90 + 8'(ngrant); r1b = 8'h0F; r1cin = 1'b1; r1sel = sels[ngrant % 4];
      #1;
      if (rv) begin
        check("rsp_id", 32'(rid), 32'(id_q.pop_front()));
        check("rsp_d", 32'(rd), 32'(d_q.pop_front()));
        nrsp++;
      end
      if (r0rdy && r1rdy) check("both_ready", 32'(1), 32'(0));
      if (r0rdy || r1rdy) begin
        exp_id = (en0 && en1) ? (first_id ^ 1'(ngrant % 2)) : en1;
        check("grant_id", 32'(r1rdy), 32'(exp_id));
        if (ngrant == 0) first_cyc = cyc;
        check("grant_spacing", 32'(cyc - first_cyc), 32'(3 * ngrant));
        if (r1rdy) r = alu_f(r1a, r1b, r1cin, r1sel);
        else       r = alu_f(r0a, r0b, r0cin, r0sel);
        exp_a = r1rdy ? r1a : r0a;
        id_q.push_back(r1rdy);
        d_q.push_back(r[7:0]);
        @(negedge clk);
        check("alu_a_loaded", 32'(aa), 32'(exp_a));
        r0v = 1'b0; r1v = 1'b0;
        cyc++;
        ngrant++;
      end
    end
    check("ops_completed", 32'(nrsp), 32'(n));
    r0v = 1'b0; r1v = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    r0v = 0; r1v = 0; r0a = 0; r0b = 0; r1a = 0; r1b = 0;
    r0cin = 0; r1cin = 0; r0sel = 0; r1sel = 0;
    q0v = 0; q0a = 0; q0b = 0; q0sel = 0; a3d = 8'h00; a3c = 0; a3z = 0;

    // Reset state
    @(negedge clk); #1;
    check("rst_alu", 32'({aa, ab, acin, as}), 32'(0));
    check("rst_rsp", 32'({rv, rid, rd, rcout, rz}), 32'(0));
    check("rst_busy", 32'({bsy, r0rdy, r1rdy}), 32'(0));
    @(negedge clk);
    rst = 1'b0;
    r1v = 1'b1;
    #1;
    check("req1_ready_now", 32'({r0rdy, r1rdy}), 32'(1));
    r1v = 1'b0;   // withdrawn before the edge: no grant

    // Single op, SETTLE=1: 26+40+1 = 67
    @(negedge clk); #1;
    check("no_grant_after_drop", 32'(bsy), 32'(0));
    r0v = 1'b1; r0a = 8'd26; r0b = 8'd40; r0cin = 1'b1; r0sel = 4'b0000;
    #1;
    check("req0_ready", 32'(r0rdy), 32'(1));
    @(negedge clk);
    r0v = 1'b0;
    #1;
    check("alu_ab", 32'({aa, ab}), 32'({8'd26, 8'd40}));
    check("busy_exec", 32'({bsy, rv}), 32'(2));
    @(negedge clk); #1;
    check("rsp_single", 32'({rv, rid, rd, rcout, rz}), 32'({1'b1, 1'b0, 8'd67, 1'b0, 1'b0}));
    @(negedge clk); #1;
    check("idle_after", 32'({bsy, rv}), 32'(0));
    check("rsp_hold", 32'(rd), 32'(67));

    // Reset restores priority to req0, then 8 contended ops
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    run_ops(8, 1'b1, 1'b1, 1'b0);

    // Lone requester 1
    run_ops(4, 1'b0, 1'b1, 1'b1);

    // Reset mid-op: req0 served last, so only reset can give req0 the next contention
    run_ops(1, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    r0v = 1'b1; r0a = 8'h33; r0b = 8'h11; r0sel = 4'b0000;
    @(negedge clk);
    r0v = 1'b0;
    rst = 1'b1;
    #1;
    check("midrst_alu", 32'({aa, ab, acin, as}), 32'(0));
    check("midrst_busy", 32'({bsy, rv}), 32'(0));
    @(negedge clk);
    rst = 1'b0;
    begin
      int pulses = 0;
      for (int i = 0; i < 3; i++) begin
        @(negedge clk); #1;
        if (rv) pulses++;
      end
      check("midrst_no_rsp", 32'(pulses), 32'(0));
    end
    run_ops(2, 1'b1, 1'b1, 1'b0);

    // SETTLE=3 instance: only the value present before E0+3 is captured
    @(negedge clk);
    q0v = 1'b1; q0a = 8'd40; q0b = 8'd40; q0sel = 4'b0100;
    #1;
    check("s3_ready", 32'(q0rdy), 32'(1));
    @(negedge clk);   // after E0
    q0v = 1'b0; a3d = 8'hAA; a3z = 1'b0;
    #1;
    check("s3_alu_ab", 32'({a3a, a3b, a3s}), 32'({8'd40, 8'd40, 4'b0100}));
    @(negedge clk);   // after E0+1
    a3d = 8'h55;
    #1;
    check("s3_not_yet", 32'({r3v, bsy3}), 32'(1));
    @(negedge clk);   // after E0+2
    a3d = 8'h00; a3z = 1'b1;
    #1;
    check("s3_not_yet2", 32'(r3v), 32'(0));
    @(negedge clk); #1; // after E0+3
    check("s3_rsp", 32'({r3v, r3id, r3d, r3c, r3z}), 32'({1'b1, 1'b0, 8'h00, 1'b0, 1'b1}));
    a3d = 8'hFF; a3z = 1'b0;
    @(negedge clk); #1;
    check("s3_done", 32'({r3v, bsy3, r3d, r3z}), 32'({1'b0, 1'b0, 8'h00, 1'b1}));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
